// File: rtl/axi3_burst.sv
// AXI3 slave bridge: one burst at a time from GP0 onto a simple req/ack local bus.
// Reads and writes arbitrate with alternating priority; INCR and FIXED bursts only.
module axi3_burst #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gp0_awvalid,
  output logic                  gp0_awready,
  input  logic [ID_W-1:0]       gp0_awid,
  input  logic [31:0]           gp0_awaddr,
  input  logic [3:0]            gp0_awlen,
  input  logic [1:0]            gp0_awburst,
  input  logic                  gp0_arvalid,
  output logic                  gp0_arready,
  input  logic [ID_W-1:0]       gp0_arid,
  input  logic [31:0]           gp0_araddr,
  input  logic [3:0]            gp0_arlen,
  input  logic [1:0]            gp0_arburst,
  input  logic                  gp0_wvalid,
  output logic                  gp0_wready,
  input  logic [ID_W-1:0]       gp0_wid,
  input  logic [DATA_W-1:0]     gp0_wdata,
  input  logic [DATA_W/8-1:0]   gp0_wstrb,
  input  logic                  gp0_wlast,
  output logic                  gp0_bvalid,
  input  logic                  gp0_bready,
  output logic [ID_W-1:0]       gp0_bid,
  output logic [1:0]            gp0_bresp,
  output logic                  gp0_rvalid,
  input  logic                  gp0_rready,
  output logic [ID_W-1:0]       gp0_rid,
  output logic [1:0]            gp0_rresp,
  output logic [DATA_W-1:0]     gp0_rdata,
  output logic                  gp0_rlast,
  output logic [31:0]           arm_addr,
  output logic [DATA_W-1:0]     arm_wdata,
  output logic [DATA_W/8-1:0]   arm_wstrb,
  input  logic [DATA_W-1:0]     arm_rdata,
  output logic                  arm_req,
  output logic                  arm_wr,
  input  logic                  arm_ack,
  input  logic                  arm_err
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_RACC, S_RDATA, S_WDATA, S_WACC, S_WRESP} state_t;

  state_t                r_state, w_next;
  logic [ID_W-1:0]       r_id;
  logic [31:0]           r_addr;
  logic [3:0]            r_len, r_beat;
  logic [1:0]            r_burst, r_rresp;
  logic                  r_err, r_prio_w;
  logic [DATA_W-1:0]     r_rdata, r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [31:0]           r_tmo;

  logic                  w_grant_w, w_last, w_unsup, w_tmo, w_done, w_done_err, w_wid_ok;
  logic [31:0]           w_step_addr, w_aw_addr, w_ar_addr;

  assign w_grant_w   = gp0_awvalid & (~gp0_arvalid | r_prio_w);
  assign gp0_awready = (r_state == S_IDLE) & gp0_awvalid & w_grant_w;
  assign gp0_arready = (r_state == S_IDLE) & gp0_arvalid & ~w_grant_w;

  assign w_aw_addr   = gp0_awaddr & ~(32'(STRB_W) - 32'd1);
  assign w_ar_addr   = gp0_araddr & ~(32'(STRB_W) - 32'd1);
  assign w_last      = (r_beat == r_len);
  assign w_unsup     = r_burst[1];
  assign w_wid_ok    = (gp0_wid == r_id);
  assign w_step_addr = (r_burst == 2'b01) ? r_addr + 32'(STRB_W) : r_addr;

  // A timeout behaves exactly like an ack carrying an error.
  assign w_tmo      = (TIMEOUT != 0) && (r_tmo == TIMEOUT - 1);
  assign w_done     = arm_req & (arm_ack | w_tmo);
  assign w_done_err = arm_ack ? arm_err : 1'b1;

  assign arm_req    = ((r_state == S_RACC) & ~w_unsup) | (r_state == S_WACC);
  assign arm_wr     = (r_state == S_WACC);
  assign arm_addr   = r_addr;
  assign arm_wdata  = r_wdata;
  assign arm_wstrb  = r_wstrb;

  assign gp0_wready = (r_state == S_WDATA);
  assign gp0_bvalid = (r_state == S_WRESP);
  assign gp0_bid    = r_id;
  assign gp0_bresp  = r_err ? 2'b10 : 2'b00;
  assign gp0_rvalid = (r_state == S_RDATA);
  assign gp0_rid    = r_id;
  assign gp0_rresp  = r_rresp;
  assign gp0_rdata  = r_rdata;
  assign gp0_rlast  = (r_state == S_RDATA) & w_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (gp0_awready) w_next = S_WDATA;
               else if (gp0_arready) w_next = S_RACC;
      S_RACC:  if (w_unsup || w_done) w_next = S_RDATA;
      S_RDATA: if (gp0_rready) w_next = w_last ? S_IDLE : S_RACC;
      S_WDATA: if (gp0_wvalid) begin
                 if (!w_wid_ok || w_unsup) w_next = w_last ? S_WRESP : S_WDATA;
                 else                      w_next = S_WACC;
               end
      S_WACC:  if (w_done) w_next = w_last ? S_WRESP : S_WDATA;
      S_WRESP: if (gp0_bready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_burst  <= '0;
      r_rresp  <= '0;
      r_err    <= 1'b0;
      r_prio_w <= 1'b1;
      r_rdata  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_tmo    <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (arm_req && !w_done) ? r_tmo + 32'd1 : '0;
      case (r_state)
        S_IDLE: begin
          if (gp0_awready) begin
            r_id     <= gp0_awid;
            r_addr   <= w_aw_addr;
            r_len    <= gp0_awlen;
            r_burst  <= gp0_awburst;
            r_beat   <= '0;
            r_err    <= gp0_awburst[1];
            r_prio_w <= 1'b0;
          end else if (gp0_arready) begin
            r_id     <= gp0_arid;
            r_addr   <= w_ar_addr;
            r_len    <= gp0_arlen;
            r_burst  <= gp0_arburst;
            r_beat   <= '0;
            r_err    <= 1'b0;
            r_prio_w <= 1'b1;
          end
        end
        S_RACC: begin
          if (w_unsup) begin
            r_rdata <= '0;
            r_rresp <= 2'b10;
          end else if (w_done) begin
            r_rdata <= arm_ack ? arm_rdata : '0;
            r_rresp <= w_done_err ? 2'b10 : 2'b00;
          end
        end
        S_RDATA: begin
          if (gp0_rready && !w_last) begin
            r_beat <= r_beat + 4'd1;
            r_addr <= w_step_addr;
          end
        end
        S_WDATA: begin
          if (gp0_wvalid) begin
            r_wdata <= gp0_wdata;
            r_wstrb <= gp0_wstrb;
            r_err   <= r_err | (gp0_wlast != w_last) | ~w_wid_ok;
            // Dropped beats still advance the burst so later beats land at their own address.
            if ((!w_wid_ok || w_unsup) && !w_last) begin
              r_beat <= r_beat + 4'd1;
              r_addr <= w_step_addr;
            end
          end
        end
        S_WACC: begin
          if (w_done) begin
            r_err <= r_err | w_done_err;
            if (!w_last) begin
              r_beat <= r_beat + 4'd1;
              r_addr <= w_step_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi3_burst.md
AXI3_BURST -- requirements
Module: axi3_burst

Interface
REQ-001 DATA_W, 32, data width in bits; 32 or 64 only.
REQ-002 ID_W, 12, AXI transaction ID width.
REQ-003 TIMEOUT, 255, max cycles waiting for arm_ack per beat; 0 disables timeout.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 gp0_awvalid, gp0_arvalid  in  1  address valid (write, read).
REQ-007 gp0_awready, gp0_arready  out  1  address accept.
REQ-008 gp0_awid, gp0_arid  in  ID_W  transaction ID.
REQ-009 gp0_awaddr, gp0_araddr  in  32  start byte address.
REQ-010 gp0_awlen, gp0_arlen  in  4  beats minus one.
REQ-011 gp0_awburst, gp0_arburst  in  2  0=FIXED, 1=INCR, 2/3 unsupported.
REQ-012 gp0_wvalid / gp0_wready  in / out  1  write data handshake.
REQ-013 gp0_wid  in  ID_W  write data ID.
REQ-014 gp0_wdata / gp0_wstrb  in  DATA_W / DATA_W/8  write data, byte strobes.
REQ-015 gp0_wlast  in  1  last write beat marker.
REQ-016 gp0_bvalid, gp0_rvalid  out  1  response valid (write, read).
REQ-017 gp0_bready, gp0_rready  in  1  response accept.
REQ-018 gp0_bid, gp0_rid  out  ID_W  response ID.
REQ-019 gp0_bresp, gp0_rresp  out  2  0=OKAY, 2=SLVERR.
REQ-020 gp0_rdata / gp0_rlast  out  DATA_W / 1  read data, last beat.
REQ-021 arm_addr  out  32  local byte address, aligned to DATA_W/8.
REQ-022 arm_wdata / arm_wstrb  out  DATA_W / DATA_W/8  local write data, strobes.
REQ-023 arm_rdata  in  DATA_W  local read data, valid when arm_ack=1.
REQ-024 arm_req  out  1  local access request, held until ack or timeout.
REQ-025 arm_wr  out  1  1=write, 0=read; stable while arm_req=1.
REQ-026 arm_ack  in  1  local access complete.
REQ-027 arm_err  in  1  local error, sampled with arm_ack.

Function
REQ-028 FSM states: IDLE, RACC, RDATA, WDATA, WACC, WRESP; one transaction at a time, no overlap.
REQ-029 IDLE: gp0_awready=gp0_awvalid&grant_w, gp0_arready=gp0_arvalid&!grant_w; both valid -> priority alternates per accepted transaction, write first after reset; one valid -> it wins.
REQ-030 On accept latch id, addr (low bits cleared to DATA_W/8 alignment), len, burst, beat counter=0, error flag=0; read -> RACC, write -> WDATA.
REQ-031 RACC: arm_req=1, arm_wr=0 from the cycle after entry; on arm_ack latch arm_rdata, rresp=arm_err?2:0, drop arm_req next cycle, go RDATA.
REQ-032 RDATA: gp0_rvalid=1, rlast=(beat==len); on rready: last -> IDLE, else beat+1, address step, RACC.
REQ-033 WDATA: gp0_wready=1; on wvalid latch wdata/wstrb -> WACC; wid!=latched id -> beat not issued locally, error flag set, stay in WDATA for next beat (or WRESP if last).
REQ-034 WACC: arm_req=1, arm_wr=1; on arm_ack OR arm_err into error flag; not last -> beat+1, address step, WDATA; last -> WRESP.
REQ-035 wlast disagreeing with beat==len sets error flag; burst length always len+1 from AW.
REQ-036 WRESP: gp0_bvalid=1, bid=latched id, bresp=flag?2:0; hold until bready, then IDLE.
REQ-037 Address step: INCR adds DATA_W/8, wraps modulo 2^32; FIXED holds address.
REQ-038 burst 2/3: no local access; read returns len+1 beats rdata=0, rresp=2; write consumes len+1 W beats, bresp=2.
REQ-039 TIMEOUT>0: arm_req held TIMEOUT cycles without ack -> drop arm_req, treat as arm_ack with arm_err=1.
REQ-040 arm_ack while arm_req=0 ignored.

Reset
REQ-041 reset=1: state IDLE, all valid/ready/arm_req/arm_wr 0, resp/id/data/addr outputs 0, priority to write; mid-burst reset abandons transaction with no response.

Verification
REQ-042 AW id=0xABC addr=0xDEADBEEF len=0 INCR, one W beat, ack err=0 -> arm_addr=0xDEADBEEC, arm_wr=1, bid=0xABC, bresp=0.
REQ-043 AR id=0x123 addr=0x1000 len=3 INCR, acks rdata 1..4 -> arm_addr 0x1000,0x1004,0x1008,0x100C, four R beats, rlast on 4th only.
REQ-044 awvalid and arvalid same cycle, twice -> write, read, then write, read order.
REQ-045 write len=1, second beat arm_err=1 -> bresp=2; same burst with wid=0x000 on beat 1 -> no arm_req for that beat, bresp=2.
REQ-046 TIMEOUT=4, arm_ack never asserted on read -> arm_req drops after 4 cycles, rresp=2.
REQ-047 AR burst=2 len=1 -> two R beats rdata=0, rresp=2, no arm_req; rready=0 holds rvalid and rdata stable.
